vector_execute_sequencer: RTL and testbench
===========================================

Name: vector_execute_sequencer

Overview:
Parametrised next-generation vector execute stage. Processes a vectorSize-lane vector through a smaller bank of aluLanes physical ALUs over several passes, with per-lane masking. Accumulates negative/zero flags across passes and resolves a generalised branch condition from the architectural flag register. Sits between decode/register-read and writeback, and connects to both with valid/ready handshakes.

Parameters:
registerSize, 8, bits per vector element
vectorSize, 8, elements per vector
aluLanes, 2, physical ALUs; vectorSize must be an integer multiple of aluLanes; passes P = vectorSize/aluLanes

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operation presented
in_ready  out  1  stage can accept (high only in IDLE)
ExecuteOp  in  3  ALU operation
overwriteFlags  in  1  commit this op's flags to flag register
pcWrEn  in  3  branch condition select
lane_mask  in  vectorSize  1 = lane active
vect1, vect2  in  vectorSize*registerSize  operand vectors, lane i at [i]
vect_out  out  vectorSize*registerSize  result vector
out_valid  out  1  result available
out_ready  in  1  downstream accepts
pcWrEn_out  out  1  branch taken
flags_out  out  2  architectural flags {Z,N}

Behaviour:
- Reset (reset=0, async): state IDLE; pass counter 0; result buffer, vect_out, latched operands/controls 0; flag register {Z,N}=00; out_valid=0; pcWrEn_out=0. Reset mid-operation discards the op; no flag update.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. Edge with in_valid=1 latches ExecuteOp, overwriteFlags, pcWrEn, lane_mask, vect1, vect2; clears pass counter and accumulators (accN=0, accZ=1); goes to RUN.
- RUN: in_ready=0. Each edge computes lanes p*aluLanes .. p*aluLanes+aluLanes-1 for pass p and writes them into the result buffer. Increments p. After pass P-1 goes to DONE, with p reset to 0.
- ALU per lane, result truncated to registerSize, wrap-around on overflow: 000 a+b; 001 a-b; 010 a&b; 011 a|b; 100 a^b; 101 a<<b[log2(registerSize)-1:0]; 110 a>>b[same], logical; 111 b.
- Masked lane (mask bit 0): result = vect1 lane unchanged; excluded from flags.
- Flag accumulation over active lanes: accN |= result MSB; accZ &= (result==0). All lanes masked -> N=0, Z=1.
- DONE: out_valid=1. vect_out holds the full result and is stable until the handshake. in_ready=0.
- The handshake edge (out_valid & out_ready) returns to IDLE and clears out_valid. If overwriteFlags, {Z,N} <= {accZ,accN} on that edge. No flag change otherwise.
- A new input is not accepted on the handshake edge. Throughput is one op per P+2 cycles.
- Latency: accept on edge E0, out_valid high after edge E(P). With defaults, out_valid rises 4 edges after accept.
- pcWrEn_out is combinational and valid only while out_valid=1 (else 0). It evaluates the flag register value before this op's commit: 000 0; 001 N; 010 Z; 100 ~Z; 011 ~N&~Z; 101 1 (unconditional); 110, 111 0.
- out_ready held low: stays in DONE indefinitely, with outputs frozen.
- vect_out is not cleared on return to IDLE; it keeps the last result.
- flags_out always reflects the flag register.

Test Plan:
- Reset: drive reset=0 mid-RUN -> out_valid=0, flags_out=00, in_ready=1 immediately after release, vect_out=0.
- ADD, all lanes active, vect1 lanes=8'hFF, vect2 lanes=8'h01, overwriteFlags=1 -> out_valid after 4 edges, all lanes 8'h00. After handshake, flags_out Z=1, N=0.
- SUB with mask 8'b0000_0001, lane0 3-5, other lanes vect1=8'h10 -> lane0=8'hFE, lanes1-7=8'h10. After commit N=1, Z=0.
- Branch: with flags Z=1 from prior op, issue op with pcWrEn=100 -> pcWrEn_out=0; pcWrEn=010 -> 1; pcWrEn=101 -> 1; pcWrEn=011 -> 0.
- Backpressure: out_ready=0 for 10 cycles in DONE -> vect_out stable, in_ready=0, in_valid ignored. A second op is accepted only on the edge after the handshake.
- Shift/mask corner: SHL a=8'h81, b=8'h09 (amount 1) -> 8'h02. Mask=0 with overwriteFlags=1 -> vect_out=vect1, flags {Z,N}=10.

Source files
------------

// File: rtl/vector_execute_sequencer.sv
// Vector execute stage: runs a vectorSize-lane operation through aluLanes
// shared ALUs over several passes, with per-lane masking, flag accumulation
// and branch-condition resolution against the architectural {Z,N} register.
module vector_execute_sequencer #(
  parameter int registerSize = 8,
  parameter int vectorSize   = 8,
  parameter int aluLanes     = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [2:0]                         ExecuteOp,
  input  logic                               overwriteFlags,
  input  logic [2:0]                         pcWrEn,
  input  logic [vectorSize-1:0]              lane_mask,
  input  logic [vectorSize*registerSize-1:0] vect1,
  input  logic [vectorSize*registerSize-1:0] vect2,
  output logic [vectorSize*registerSize-1:0] vect_out,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               pcWrEn_out,
  output logic [1:0]                         flags_out
);

  localparam int PASSES = vectorSize / aluLanes;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int SH_W   = (registerSize > 1) ? $clog2(registerSize) : 1;

  typedef logic [registerSize-1:0] elem_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pass_q;
  logic [2:0]         op_q;
  logic               ovf_q;
  logic [2:0]         sel_q;
  logic [vectorSize-1:0] mask_q;
  elem_t              a_q    [vectorSize];
  elem_t              b_q    [vectorSize];
  elem_t              res_q  [vectorSize];
  elem_t              vout_q [vectorSize];
  elem_t              res_d  [vectorSize];
  elem_t              a_sel  [aluLanes];
  elem_t              b_sel  [aluLanes];
  elem_t              alu_r  [aluLanes];
  logic [aluLanes-1:0] m_sel;
  logic               acc_n_q, acc_z_q;
  logic               pass_n, pass_z;
  logic [1:0]         flags_q;
  logic               last_pass;

  function automatic elem_t alu(input logic [2:0] op, input elem_t a, input elem_t b);
    case (op)
      3'b000:  alu = a + b;
      3'b001:  alu = a - b;
      3'b010:  alu = a & b;
      3'b011:  alu = a | b;
      3'b100:  alu = a ^ b;
      3'b101:  alu = a << b[SH_W-1:0];
      3'b110:  alu = a >> b[SH_W-1:0];
      default: alu = b;
    endcase
  endfunction

  assign last_pass = (pass_q == CNT_W'(PASSES - 1));
  assign flags_out = flags_q;

  // State register for the IDLE/RUN/DONE sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_pass) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Route the current pass's lanes onto the shared ALUs and merge results back
  always_comb begin
    res_d  = res_q;
    pass_n = 1'b0;
    pass_z = 1'b1;
    for (int j = 0; j < aluLanes; j++) begin
      a_sel[j] = '0;
      b_sel[j] = '0;
      m_sel[j] = 1'b0;
    end
    for (int p = 0; p < PASSES; p++) begin
      if (pass_q == CNT_W'(p)) begin
        for (int j = 0; j < aluLanes; j++) begin
          a_sel[j] = a_q[p*aluLanes + j];
          b_sel[j] = b_q[p*aluLanes + j];
          m_sel[j] = mask_q[p*aluLanes + j];
        end
      end
    end
    for (int j = 0; j < aluLanes; j++) begin
      alu_r[j] = m_sel[j] ? alu(op_q, a_sel[j], b_sel[j]) : a_sel[j];
      if (m_sel[j]) begin
        pass_n = pass_n | alu_r[j][registerSize-1];
        pass_z = pass_z & (alu_r[j] == '0);
      end
    end
    for (int p = 0; p < PASSES; p++) begin
      if (pass_q == CNT_W'(p)) begin
        for (int j = 0; j < aluLanes; j++) res_d[p*aluLanes + j] = alu_r[j];
      end
    end
  end

  // Operand latching, per-pass result/flag accumulation and flag commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_q  <= '0;
      op_q    <= '0;
      ovf_q   <= 1'b0;
      sel_q   <= '0;
      mask_q  <= '0;
      acc_n_q <= 1'b0;
      acc_z_q <= 1'b1;
      flags_q <= 2'b00;
      for (int i = 0; i < vectorSize; i++) begin
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        res_q[i]  <= '0;
        vout_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= ExecuteOp;
            ovf_q   <= overwriteFlags;
            sel_q   <= pcWrEn;
            mask_q  <= lane_mask;
            pass_q  <= '0;
            acc_n_q <= 1'b0;
            acc_z_q <= 1'b1;
            for (int i = 0; i < vectorSize; i++) begin
              a_q[i] <= vect1[i*registerSize +: registerSize];
              b_q[i] <= vect2[i*registerSize +: registerSize];
            end
          end
        end
        RUN: begin
          res_q   <= res_d;
          acc_n_q <= acc_n_q | pass_n;
          acc_z_q <= acc_z_q & pass_z;
          if (last_pass) begin
            pass_q <= '0;
            vout_q <= res_d;
          end else begin
            pass_q <= pass_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready && ovf_q) flags_q <= {acc_z_q, acc_n_q};
        end
        default: ;
      endcase
    end
  end

  // Branch condition from the pre-commit flag register, only while a result is offered
  always_comb begin
    pcWrEn_out = 1'b0;
    if (out_valid) begin
      case (sel_q)
        3'b001:  pcWrEn_out = flags_q[0];
        3'b010:  pcWrEn_out = flags_q[1];
        3'b100:  pcWrEn_out = ~flags_q[1];
        3'b011:  pcWrEn_out = ~flags_q[0] & ~flags_q[1];
        3'b101:  pcWrEn_out = 1'b1;
        default: pcWrEn_out = 1'b0;
      endcase
    end
  end

  // Flatten the held result onto the output bus
  always_comb begin
    for (int i = 0; i < vectorSize; i++) vect_out[i*registerSize +: registerSize] = vout_q[i];
  end

endmodule

// File: tb/tb_vector_execute_sequencer.sv
// Self-checking bench for vector_execute_sequencer: a transaction-level model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_vector_execute_sequencer;

  localparam int R = 8;
  localparam int V = 8;
  localparam int L = 2;
  localparam int P = V / L;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2:0]     ExecuteOp = '0;
  logic           overwriteFlags = 1'b0;
  logic [2:0]     pcWrEn = '0;
  logic [V-1:0]   lane_mask = '0;
  logic [V*R-1:0] vect1 = '0;
  logic [V*R-1:0] vect2 = '0;
  logic [V*R-1:0] vect_out;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           pcWrEn_out;
  logic [1:0]     flags_out;

  int checks = 0;
  int passes = 0;

  // Transaction-level model state
  logic           m_busy = 1'b0;
  int             m_since = 0;
  logic [V*R-1:0] m_pending = '0;
  logic [V*R-1:0] m_vout = '0;
  logic           m_pz = 1'b1;
  logic           m_pn = 1'b0;
  logic           m_ovf = 1'b0;
  logic [2:0]     m_sel = '0;
  logic [1:0]     m_flags = 2'b00;

  vector_execute_sequencer #(.registerSize(R), .vectorSize(V), .aluLanes(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ExecuteOp(ExecuteOp), .overwriteFlags(overwriteFlags), .pcWrEn(pcWrEn),
    .lane_mask(lane_mask), .vect1(vect1), .vect2(vect2), .vect_out(vect_out),
    .out_valid(out_valid), .out_ready(out_ready), .pcWrEn_out(pcWrEn_out),
    .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck design still ends the run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  function automatic logic [R-1:0] expectLane(input logic [2:0] op, input logic [R-1:0] a, input logic [R-1:0] b);
    int sh;
    sh = int'(b) % R;
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a << sh;
      3'b110:  return a >> sh;
      default: return b;
    endcase
  endfunction

  function automatic logic expectBranch(input logic [2:0] sel, input logic [1:0] fl);
    case (sel)
      3'b001:  return fl[0];
      3'b010:  return fl[1];
      3'b100:  return !fl[1];
      3'b011:  return !fl[0] && !fl[1];
      3'b101:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Whole-vector result and flags for an accepted operation
  task automatic modelOp();
    logic [R-1:0] a, r;
    m_pn = 1'b0;
    m_pz = 1'b1;
    for (int i = 0; i < V; i++) begin
      a = vect1[i*R +: R];
      if (lane_mask[i]) begin
        r = expectLane(ExecuteOp, a, vect2[i*R +: R]);
        m_pn = m_pn | r[R-1];
        m_pz = m_pz & (r == '0);
      end else begin
        r = a;
      end
      m_pending[i*R +: R] = r;
    end
    m_ovf = overwriteFlags;
    m_sel = pcWrEn;
  endtask

  // Model timing: accept, P edges of work, then wait for the output handshake
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_since = 0;
      m_vout = '0;
      m_flags = 2'b00;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_since = 0;
        modelOp();
      end
    end else if (m_since < P) begin
      m_since++;
      if (m_since == P) m_vout = m_pending;
    end else if (out_ready) begin
      m_busy = 1'b0;
      if (m_ovf) m_flags = {m_pz, m_pn};
    end
  end

  // Per-cycle comparison of every meaningful output against the model
  always @(negedge clk) begin
    logic exp_ov;
    if (reset === 1'b1) begin
      exp_ov = m_busy && (m_since == P);
      checkOutput("in_ready", in_ready, !m_busy);
      checkOutput("out_valid", out_valid, exp_ov);
      checkOutput("flags_out", flags_out, m_flags);
      checkOutput("pcWrEn_out", pcWrEn_out, exp_ov ? expectBranch(m_sel, m_flags) : 1'b0);
      if (!m_busy || exp_ov) checkOutput("vect_out", vect_out, m_vout);
    end
  end

  // Present one operation at a negedge while idle; it is accepted on the next edge
  task automatic applyStimulus(input logic [2:0] op, input logic ovf, input logic [2:0] sel,
                               input logic [V-1:0] mask, input logic [V*R-1:0] v1, input logic [V*R-1:0] v2);
    ExecuteOp = op;
    overwriteFlags = ovf;
    pcWrEn = sel;
    lane_mask = mask;
    vect1 = v1;
    vect2 = v2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid, returning the number of cycles it took
  task automatic waitDone(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_out_valid", out_valid, 1'b1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Directed scenarios
  initial begin
    int lat;
    logic [2:0] bsel [4];
    logic       bexp [4];
    bsel[0] = 3'b100; bexp[0] = 1'b0;
    bsel[1] = 3'b010; bexp[1] = 1'b1;
    bsel[2] = 3'b101; bexp[2] = 1'b1;
    bsel[3] = 3'b011; bexp[3] = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a run discards the op
    applyStimulus(3'b000, 1'b1, 3'b000, 8'hFF, {8{8'hFF}}, {8{8'h01}});
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_flags", flags_out, 2'b00);
    checkOutput("reset_vect_out", vect_out, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // ADD wrap-around to zero, flags committed
    applyStimulus(3'b000, 1'b1, 3'b000, 8'hFF, {8{8'hFF}}, {8{8'h01}});
    waitDone(lat);
    checkOutput("add_latency", 64'(lat), 64'd4);
    checkOutput("add_result", vect_out, 64'h0);
    handshake();
    checkOutput("add_flags", flags_out, 2'b10);

    // Branch conditions against Z=1, N=0
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b111, 1'b0, bsel[k], 8'hFF, 64'h0, 64'h0);
      waitDone(lat);
      checkOutput("branch_taken", pcWrEn_out, bexp[k]);
      handshake();
    end

    // SUB on lane 0 only
    applyStimulus(3'b001, 1'b1, 3'b000, 8'b0000_0001, {{7{8'h10}}, 8'h03}, 64'h05);
    waitDone(lat);
    checkOutput("sub_result", vect_out, {{7{8'h10}}, 8'hFE});
    handshake();
    checkOutput("sub_flags", flags_out, 2'b01);

    // Backpressure: result held, new input ignored until after the handshake
    applyStimulus(3'b000, 1'b0, 3'b000, 8'hFF, 64'h0102030405060708, {8{8'h10}});
    waitDone(lat);
    ExecuteOp = 3'b100;
    overwriteFlags = 1'b0;
    pcWrEn = 3'b001;
    lane_mask = 8'hFF;
    vect1 = 64'hFFFF0000FFFF0000;
    vect2 = {8{8'h0F}};
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("bp_vect_out", vect_out, 64'h1112131415161718);
      checkOutput("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_no_accept_on_handshake", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_accept_next_edge", in_ready, 1'b0);
    waitDone(lat);
    checkOutput("bp_second_result", vect_out, 64'hF0F00F0FF0F00F0F);
    handshake();

    // Shift amount uses only the low bits of b
    applyStimulus(3'b101, 1'b0, 3'b000, 8'hFF, {8{8'h81}}, {8{8'h09}});
    waitDone(lat);
    checkOutput("shl_result", vect_out, {8{8'h02}});
    handshake();

    // All lanes masked: passthrough, flags Z=1 N=0
    applyStimulus(3'b000, 1'b1, 3'b000, 8'h00, 64'h8899AABBCCDDEEFF, {8{8'h77}});
    waitDone(lat);
    checkOutput("mask0_result", vect_out, 64'h8899AABBCCDDEEFF);
    handshake();
    checkOutput("mask0_flags", flags_out, 2'b10);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
